// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch / load-store) in front of the data-path RAM.
// Round-robin on ties, alignment pre-check on data requests, bounded wait on mfc.
module mem_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_data,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic              d_sig,
    input  logic [1:0]        d_len,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              err,
    output logic              busy,
    output logic              ram_enable,
    output logic              ram_read_write,
    output logic              ram_sig,
    output logic [1:0]        ram_data_length,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_data_in,
    input  logic [31:0]       ram_data_out,
    input  logic              ram_mfc
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic G_FETCH = 1'b0;
    localparam logic G_DATA  = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic              sig_q, sig_d;
    logic [1:0]        len_q, len_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic any_req, pick_data, d_bad, tmo;

    // Data port wins when it is alone or when fetch was served last.
    assign any_req   = if_req | d_req;
    assign pick_data = d_req & (~if_req | (last_q == G_FETCH));
    assign d_bad     = (d_len == 2'd3) ||
                       (d_len == 2'd1 && d_addr[0]) ||
                       (d_len == 2'd2 && d_addr[1:0] != 2'b00);
    assign tmo       = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = (pick_data && d_bad) ? S_DONE : S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (ram_mfc || tmo) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        last_d  = last_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        sig_d   = sig_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d   = pick_data;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = pick_data & d_bad;
                    if (pick_data) begin
                        addr_d  = d_addr;
                        rw_d    = d_rw;
                        sig_d   = d_sig;
                        len_d   = d_len;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = if_addr;
                        rw_d    = 1'b1;
                        sig_d   = 1'b0;
                        len_d   = 2'd2;
                        wdata_d = '0;
                    end
                end
            end
            S_WAIT: begin
                if (ram_mfc) begin
                    rdata_d = ram_data_out;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (tmo) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            S_DONE: begin
                last_d = gnt_q;
                cnt_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q  <= G_FETCH;
            gnt_q   <= G_FETCH;
            addr_q  <= '0;
            rw_q    <= 1'b1;
            sig_q   <= 1'b0;
            len_q   <= 2'd0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            sig_q   <= sig_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    always_comb begin
        busy            = (state_q != S_IDLE);
        ram_enable      = (state_q == S_ISSUE);
        ram_read_write  = rw_q;
        ram_sig         = sig_q;
        ram_data_length = len_q;
        ram_address     = addr_q;
        ram_data_in     = wdata_q;
        if_ack          = (state_q == S_DONE) && (gnt_q == G_FETCH);
        d_ack           = (state_q == S_DONE) && (gnt_q == G_DATA);
        err             = (state_q == S_DONE) && err_q;
        if_data         = if_ack ? rdata_q : 32'd0;
        d_rdata         = (d_ack && rw_q) ? rdata_q : 32'd0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM responder plus a byte-array reference model
// predicting data, error, latency, grant order and RAM pulse count per transaction.
module tb_mem_arbiter;
    localparam int AW = 9;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset;
    logic if_req, if_ack, d_req, d_rw, d_sig, d_ack, err, busy;
    logic [AW-1:0] if_addr, d_addr, ram_address;
    logic [1:0] d_len, ram_data_length;
    logic [31:0] if_data, d_wdata, d_rdata, ram_data_in;
    logic ram_enable, ram_read_write, ram_sig;
    logic [31:0] ram_data_out = 32'd0;
    logic ram_mfc = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
        .d_req(d_req), .d_rw(d_rw), .d_sig(d_sig), .d_len(d_len), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .err(err), .busy(busy),
        .ram_enable(ram_enable), .ram_read_write(ram_read_write), .ram_sig(ram_sig),
        .ram_data_length(ram_data_length), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .ram_mfc(ram_mfc)
    );

    // RAM responder: performs the access on the enable edge, raises mfc for one cycle
    // after mfc_dly further edges (0 = visible in the first WAIT cycle).
    logic [7:0] mem [512];
    int  pend = 0;
    int  mfc_dly = 0;
    bit  no_mfc = 1'b0;
    int  en_cnt = 0;
    logic lrw;
    logic [1:0] llen;

    always @(posedge clk) begin
        ram_mfc <= 1'b0;
        if (reset) begin
            pend = 0;
        end else if (ram_enable) begin
            int nb;
            logic [31:0] w;
            en_cnt++;
            lrw  = ram_read_write;
            llen = ram_data_length;
            nb = (ram_data_length == 2'd0) ? 1 : (ram_data_length == 2'd1) ? 2 : 4;
            w = 32'd0;
            if (!ram_read_write) begin
                for (int i = 0; i < nb; i++) mem[(int'(ram_address) + i) % 512] = ram_data_in[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) w[8*i +: 8] = mem[(int'(ram_address) + i) % 512];
                if (ram_sig && nb == 1) w = {{24{w[7]}}, w[7:0]};
                if (ram_sig && nb == 2) w = {{16{w[15]}}, w[15:0]};
            end
            ram_data_out <= w;
            if (!no_mfc) begin
                if (mfc_dly == 0) ram_mfc <= 1'b1;
                else pend = mfc_dly;
            end
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) ram_mfc <= 1'b1;
        end
    end

    // Reference model: plain byte array and integer arithmetic.
    logic [7:0] sh [512];
    bit model_last = 1'b0;  // 0 = fetch served last, 1 = data

    function automatic logic [31:0] mdl_read(int a, int len, bit sig);
        longint v = 0;
        int nb = (len == 0) ? 1 : (len == 1) ? 2 : 4;
        for (int i = 0; i < nb; i++) v += longint'(sh[(a + i) % 512]) << (8 * i);
        if (sig && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    function automatic void mdl_write(int a, int len, logic [31:0] wd);
        int nb = (len == 0) ? 1 : (len == 1) ? 2 : 4;
        for (int i = 0; i < nb; i++) sh[(a + i) % 512] = 8'(wd >> (8 * i));
    endfunction

    function automatic bit mdl_bad(int a, int len);
        return (len == 3) || (len == 1 && a % 2 != 0) || (len == 2 && a % 4 != 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One transaction on one port, starting from an idle arbiter.
    task automatic xact(input bit isf, input bit rw, input bit sig, input logic [1:0] len,
                        input logic [AW-1:0] a, input logic [31:0] wd, input int dly, input string tag);
        int e0, lat, exp_lat, exp_en;
        bit got, fport, ebad;
        logic [31:0] dat, exp_dat;
        logic er, exp_er;
        @(negedge clk);
        mfc_dly = dly;
        e0 = en_cnt;
        if (isf) begin
            if_req = 1'b1; if_addr = a;
        end else begin
            d_req = 1'b1; d_rw = rw; d_sig = sig; d_len = len; d_addr = a; d_wdata = wd;
        end
        lat = 0; got = 1'b0; fport = 1'b0; dat = '0; er = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (if_ack || d_ack) begin
                got = 1'b1; fport = d_ack; er = err;
                dat = d_ack ? d_rdata : if_data;
            end
        end
        if_req = 1'b0; d_req = 1'b0;

        ebad = !isf && mdl_bad(int'(a), int'(len));
        if (ebad) begin
            exp_lat = 1; exp_en = 0; exp_er = 1'b1; exp_dat = 32'd0;
        end else if (no_mfc) begin
            exp_lat = 2 + TO; exp_en = 1; exp_er = 1'b1; exp_dat = 32'd0;
        end else begin
            exp_lat = 3 + dly; exp_en = 1; exp_er = 1'b0;
            if (isf) exp_dat = mdl_read(int'(a), 2, 1'b0);
            else if (rw) exp_dat = mdl_read(int'(a), int'(len), sig);
            else begin mdl_write(int'(a), int'(len), wd); exp_dat = 32'd0; end
        end

        chk({tag, " ack"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, " port"}, 32'(fport), 32'(!isf));
            chk({tag, " latency"}, lat, exp_lat);
            chk({tag, " data"}, dat, exp_dat);
            chk({tag, " err"}, 32'(er), 32'(exp_er));
            model_last = !isf;
        end
        chk({tag, " enables"}, en_cnt - e0, exp_en);
    endtask

    // Both ports request in the same cycle; the round-robin rule picks the order.
    task automatic collide(input logic [AW-1:0] fa, input logic [AW-1:0] da, input string tag);
        bit exp_first, first, got;
        int n;
        logic [31:0] dat;
        @(negedge clk);
        mfc_dly = 0;
        if_req = 1'b1; if_addr = fa;
        d_req = 1'b1; d_rw = 1'b1; d_sig = 1'b0; d_len = 2'd2; d_addr = da;
        exp_first = (model_last == 1'b0);
        for (int k = 0; k < 2; k++) begin
            got = 1'b0; n = 0; first = 1'b0; dat = '0;
            while (!got && n < 40) begin
                @(negedge clk);
                n++;
                if (if_ack || d_ack) begin
                    got = 1'b1; first = d_ack; dat = d_ack ? d_rdata : if_data;
                    if (d_ack) d_req = 1'b0; else if_req = 1'b0;
                end
            end
            chk($sformatf("%s ack%0d", tag, k), 32'(got), 32'd1);
            if (got) begin
                chk($sformatf("%s order%0d", tag, k), 32'(first), 32'(k == 0 ? exp_first : !exp_first));
                chk($sformatf("%s data%0d", tag, k), dat, mdl_read(first ? int'(da) : int'(fa), 2, 1'b0));
                model_last = first;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        bit seen, saw;
        int n;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_rw = 1'b1; d_sig = 1'b0;
        d_len = 2'd0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 512; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            mem[i] = b; sh[i] = b;
        end
        for (int i = 0; i < 4; i++) begin mem[i] = 8'(i + 1); sh[i] = 8'(i + 1); end

        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset enable", 32'(ram_enable), 32'd0);
        chk("reset rw", 32'(ram_read_write), 32'd1);
        chk("reset acks", {30'd0, if_ack, d_ack}, 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset addr", 32'(ram_address), 32'd0);
        reset = 1'b0;
        model_last = 1'b0;

        // Right after reset both ports collide: data goes first, then alternation.
        collide(9'h010, 9'h020, "collide1");
        collide(9'h030, 9'h040, "collide2");

        xact(1'b1, 1'b1, 1'b0, 2'd2, 9'h000, 32'd0, 0, "fetch0");
        chk("fetch0 pin rw", 32'(lrw), 32'd1);
        chk("fetch0 pin len", 32'(llen), 32'd2);

        xact(1'b0, 1'b0, 1'b0, 2'd0, 9'h000, 32'h0000_00FF, 0, "store byte");
        xact(1'b0, 1'b1, 1'b1, 2'd1, 9'h000, 32'd0, 0, "load half signed");
        xact(1'b0, 1'b1, 1'b1, 2'd0, 9'h000, 32'd0, 1, "load byte signed");

        xact(1'b0, 1'b0, 1'b0, 2'd2, 9'h006, 32'hDEAD_BEEF, 0, "misaligned word");
        xact(1'b0, 1'b1, 1'b0, 2'd1, 9'h003, 32'd0, 0, "misaligned half");
        xact(1'b0, 1'b1, 1'b0, 2'd3, 9'h008, 32'd0, 0, "reserved len");
        xact(1'b0, 1'b1, 1'b0, 2'd2, 9'h004, 32'd0, 0, "after misaligned");

        no_mfc = 1'b1;
        xact(1'b1, 1'b1, 1'b0, 2'd2, 9'h00C, 32'd0, 0, "timeout");
        @(negedge clk);
        chk("timeout busy low", 32'(busy), 32'd0);
        no_mfc = 1'b0;

        // Reset while waiting on mfc: no ack may follow.
        @(negedge clk);
        mfc_dly = 6;
        if_req = 1'b1; if_addr = 9'h008;
        seen = 1'b0; n = 0;
        while (!seen && n < 10) begin
            @(negedge clk); n++;
            seen = ram_enable;
        end
        chk("rstwait enable seen", 32'(seen), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstwait busy", 32'(busy), 32'd0);
        chk("rstwait enable", 32'(ram_enable), 32'd0);
        chk("rstwait rw", 32'(ram_read_write), 32'd1);
        chk("rstwait acks", {30'd0, if_ack, d_ack}, 32'd0);
        chk("rstwait err", 32'(err), 32'd0);
        reset = 1'b0; if_req = 1'b0;
        model_last = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            saw |= if_ack | d_ack;
        end
        chk("rstwait no ack", 32'(saw), 32'd0);
        xact(1'b1, 1'b1, 1'b0, 2'd2, 9'h008, 32'd0, 0, "after reset fetch");

        for (int t = 0; t < 50; t++) begin
            bit isf, rw, sig;
            logic [1:0] len;
            logic [AW-1:0] a;
            isf = ($urandom_range(0, 2) == 0);
            rw  = 1'($urandom);
            sig = 1'($urandom);
            len = 2'($urandom_range(0, 3));
            a   = AW'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) begin
                if (len == 2'd1) a[0] = 1'b0;
                if (len == 2'd2) a[1:0] = 2'b00;
            end
            if (isf) a[1:0] = 2'b00;
            xact(isf, rw, sig, len, a, $urandom, $urandom_range(0, 3), $sformatf("rand%0d", t));
        end

        for (int t = 0; t < 4; t++) begin
            logic [AW-1:0] fa, da;
            fa = AW'($urandom_range(0, 127) * 4);
            da = AW'($urandom_range(0, 127) * 4);
            collide(fa, da, $sformatf("rcollide%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
